// File: rtl/exc_ctrl.sv
// exc_ctrl: exception and flush controller for the five-stage LoongArch pipeline.
// Sits beside write-back, owns the exception CSRs and the countdown timer, and
// on an exception or ertn flushes the pipeline while holding a PC redirect
// toward fetch until fetch accepts it.
//
// Ports:
//   clk, reset            - clock and synchronous active-high reset
//   ws_valid/ws_exc_vec   - WB valid and exception flags {ale,adef,ine,sys,brk,int}
//   ws_ertn, ws_pc        - WB ertn marker and PC
//   ws_vaddr              - faulting address (ALE)
//   csr_we/num/wmask/wdata- CSR write port (num is shared with the read port)
//   csr_rdata             - combinational CSR read data
//   hw_int                - external interrupt lines (ESTAT.IS[9:2])
//   has_int               - interrupt pending toward ID
//   flush                 - kill all stage valids
//   redirect_valid/pc     - redirect request toward fetch
//   fs_redirect_ready     - fetch accepts the redirect
module exc_ctrl #(
  parameter int TIMER_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_valid,
  input  logic [5:0]  ws_exc_vec,
  input  logic        ws_ertn,
  input  logic [31:0] ws_pc,
  input  logic [31:0] ws_vaddr,
  input  logic        csr_we,
  input  logic [13:0] csr_num,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  input  logic [7:0]  hw_int,
  output logic        has_int,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        fs_redirect_ready
);

  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_BADV   = 14'h007;
  localparam logic [13:0] CSR_EENTRY = 14'h00C;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;

  localparam logic [TIMER_W-1:0] TV_ZERO = {TIMER_W{1'b0}};
  localparam logic [TIMER_W-1:0] TV_ONE  = {{(TIMER_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    S_RUN   = 1'b0,
    S_REDIR = 1'b1
  } state_e;

  function automatic logic [31:0] csr_merge(input logic [31:0] old_v,
                                            input logic [31:0] mask,
                                            input logic [31:0] data);
    csr_merge = (old_v & ~mask) | (data & mask);
  endfunction

  state_e             state_q, state_d;
  logic [31:0]        target_q, target_d;
  logic [8:0]         crmd_q, crmd_d;       // DATM,DATF,PG,DA,IE,PLV
  logic [2:0]         prmd_q, prmd_d;       // PIE,PPLV
  logic [12:0]        ecfg_q, ecfg_d;       // LIE
  logic [1:0]         is_sw_q, is_sw_d;     // IS[1:0]
  logic [7:0]         is_hw_q, is_hw_d;     // IS[9:2]
  logic               is_timer_q, is_timer_d; // IS[11]
  logic [5:0]         ecode_q, ecode_d;
  logic [8:0]         esubcode_q, esubcode_d;
  logic [31:0]        era_q, era_d;
  logic [31:0]        badv_q, badv_d;
  logic [25:0]        eentry_q, eentry_d;   // EENTRY[31:6]
  logic [TIMER_W-1:0] tcfg_q, tcfg_d;
  logic [TIMER_W-1:0] tval_q, tval_d;

  logic [12:0] estat_is_s;
  logic        in_run_s;
  logic        exc_s;
  logic        ertn_s;
  logic        wr_s;
  logic [31:0] wr_val_s;
  logic [5:0]  code_s;
  logic        sel_ale_s;
  logic        sel_adef_s;
  logic        timer_set_s;
  logic        ticlr_clr_s;

  assign estat_is_s = {1'b0, is_timer_q, 1'b0, is_hw_q, is_sw_q};

  // Combinational CSR read mux; unimplemented addresses and TICLR read zero.
  always_comb begin
    csr_rdata = 32'd0;
    case (csr_num)
      CSR_CRMD:   csr_rdata = {23'd0, crmd_q};
      CSR_PRMD:   csr_rdata = {29'd0, prmd_q};
      CSR_ECFG:   csr_rdata = {19'd0, ecfg_q};
      CSR_ESTAT:  csr_rdata = {1'b0, esubcode_q, ecode_q, 3'd0, estat_is_s};
      CSR_ERA:    csr_rdata = era_q;
      CSR_BADV:   csr_rdata = badv_q;
      CSR_EENTRY: csr_rdata = {eentry_q, 6'd0};
      CSR_TCFG:   csr_rdata = 32'(tcfg_q);
      CSR_TVAL:   csr_rdata = 32'(tval_q);
      default:    csr_rdata = 32'd0;
    endcase
  end

  assign has_int        = crmd_q[2] & (|(estat_is_s & ecfg_q));
  assign flush          = (state_q == S_REDIR);
  assign redirect_valid = (state_q == S_REDIR);
  assign redirect_pc    = target_q;

  // Event qualification and exception cause selection.
  always_comb begin
    in_run_s = (state_q == S_RUN);
    exc_s    = in_run_s & ws_valid & (|ws_exc_vec);
    ertn_s   = in_run_s & ws_valid & ws_ertn & ~exc_s;
    wr_s     = in_run_s & csr_we & ~exc_s;
    // csr_rdata addresses the same register as the write, so it is the old value.
    wr_val_s = csr_merge(csr_rdata, csr_wmask, csr_wdata);
    sel_ale_s  = 1'b0;
    sel_adef_s = 1'b0;
    if (ws_exc_vec[0]) begin
      code_s = 6'h00;
    end else if (ws_exc_vec[4]) begin
      code_s     = 6'h08;
      sel_adef_s = 1'b1;
    end else if (ws_exc_vec[3]) begin
      code_s = 6'h0D;
    end else if (ws_exc_vec[2]) begin
      code_s = 6'h0B;
    end else if (ws_exc_vec[1]) begin
      code_s = 6'h0C;
    end else if (ws_exc_vec[5]) begin
      code_s    = 6'h09;
      sel_ale_s = 1'b1;
    end else begin
      code_s = 6'h00;
    end
  end

  // Next-state: FSM, CSR writes, exception/ertn side effects, timer.
  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    crmd_d      = crmd_q;
    prmd_d      = prmd_q;
    ecfg_d      = ecfg_q;
    is_sw_d     = is_sw_q;
    is_hw_d     = hw_int;
    is_timer_d  = is_timer_q;
    ecode_d     = ecode_q;
    esubcode_d  = esubcode_q;
    era_d       = era_q;
    badv_d      = badv_q;
    eentry_d    = eentry_q;
    tcfg_d      = tcfg_q;
    tval_d      = tval_q;
    timer_set_s = 1'b0;
    ticlr_clr_s = 1'b0;

    case (state_q)
      S_RUN: begin
        if (exc_s) begin
          state_d  = S_REDIR;
          target_d = {eentry_q, 6'd0};
        end else if (ertn_s) begin
          state_d  = S_REDIR;
          target_d = era_q;
        end else begin
          state_d = S_RUN;
        end
      end
      S_REDIR: begin
        if (fs_redirect_ready) begin
          state_d = S_RUN;
        end else begin
          state_d = S_REDIR;
        end
      end
      default: state_d = S_RUN;
    endcase

    // Software writes; read-only fields are simply not taken from wr_val_s.
    if (wr_s) begin
      case (csr_num)
        CSR_CRMD:   crmd_d = wr_val_s[8:0];
        CSR_PRMD:   prmd_d = wr_val_s[2:0];
        CSR_ECFG:   ecfg_d = wr_val_s[12:0];
        CSR_ESTAT: begin
          is_sw_d    = wr_val_s[1:0];
          ecode_d    = wr_val_s[21:16];
          esubcode_d = wr_val_s[30:22];
        end
        CSR_ERA:    era_d    = wr_val_s;
        CSR_BADV:   badv_d   = wr_val_s;
        CSR_EENTRY: eentry_d = wr_val_s[31:6];
        CSR_TCFG:   tcfg_d   = wr_val_s[TIMER_W-1:0];
        CSR_TICLR:  ticlr_clr_s = wr_val_s[0];
        default:    ticlr_clr_s = 1'b0;
      endcase
    end else begin
      ticlr_clr_s = 1'b0;
    end

    if (exc_s) begin
      prmd_d      = crmd_q[2:0];
      crmd_d[2:0] = 3'b000;
      ecode_d     = code_s;
      era_d       = ws_pc;
      if (sel_ale_s) begin
        badv_d = ws_vaddr;
      end else if (sel_adef_s) begin
        badv_d = ws_pc;
      end else begin
        badv_d = badv_q;
      end
    end else if (ertn_s) begin
      crmd_d[2:0] = prmd_q;
    end else begin
      prmd_d = prmd_d;
    end

    // Timer: a TCFG write with En=1 reloads; otherwise count down while enabled.
    if (wr_s && (csr_num == CSR_TCFG) && wr_val_s[0]) begin
      tval_d = {wr_val_s[TIMER_W-1:2], 2'b00};
    end else if (tcfg_q[0]) begin
      if (tval_q != TV_ZERO) begin
        tval_d      = tval_q - TV_ONE;
        timer_set_s = (tval_q == TV_ONE);
      end else if (tcfg_q[1]) begin
        tval_d = {tcfg_q[TIMER_W-1:2], 2'b00};
      end else begin
        tval_d = tval_q;
      end
    end else begin
      tval_d = tval_q;
    end

    // A timer expiry in the same cycle as a TICLR clear leaves IS[11] set.
    if (timer_set_s) begin
      is_timer_d = 1'b1;
    end else if (ticlr_clr_s) begin
      is_timer_d = 1'b0;
    end else begin
      is_timer_d = is_timer_q;
    end
  end

  // State and CSR registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_RUN;
      target_q   <= 32'd0;
      crmd_q     <= 9'h008;
      prmd_q     <= 3'd0;
      ecfg_q     <= 13'd0;
      is_sw_q    <= 2'd0;
      is_hw_q    <= 8'd0;
      is_timer_q <= 1'b0;
      ecode_q    <= 6'd0;
      esubcode_q <= 9'd0;
      era_q      <= 32'd0;
      badv_q     <= 32'd0;
      eentry_q   <= 26'd0;
      tcfg_q     <= TV_ZERO;
      tval_q     <= TV_ZERO;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      crmd_q     <= crmd_d;
      prmd_q     <= prmd_d;
      ecfg_q     <= ecfg_d;
      is_sw_q    <= is_sw_d;
      is_hw_q    <= is_hw_d;
      is_timer_q <= is_timer_d;
      ecode_q    <= ecode_d;
      esubcode_q <= esubcode_d;
      era_q      <= era_d;
      badv_q     <= badv_d;
      eentry_q   <= eentry_d;
      tcfg_q     <= tcfg_d;
      tval_q     <= tval_d;
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl. Expected redirect targets are queued when
// an event is driven and compared by a monitor while the redirect is pending.
module tb_exc_ctrl;

  logic        clk;
  logic        reset;
  logic        ws_valid;
  logic [5:0]  ws_exc_vec;
  logic        ws_ertn;
  logic [31:0] ws_pc;
  logic [31:0] ws_vaddr;
  logic        csr_we;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic [7:0]  hw_int;
  logic        has_int;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fs_redirect_ready;

  int n_chk;
  int n_pass;
  int n_extra;
  logic [31:0] exp_q[$];

  exc_ctrl #(.TIMER_W(32)) dut (
    .clk(clk), .reset(reset),
    .ws_valid(ws_valid), .ws_exc_vec(ws_exc_vec), .ws_ertn(ws_ertn),
    .ws_pc(ws_pc), .ws_vaddr(ws_vaddr),
    .csr_we(csr_we), .csr_num(csr_num), .csr_wmask(csr_wmask),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .hw_int(hw_int), .has_int(has_int), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fs_redirect_ready(fs_redirect_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] data);
    csr_we    = 1'b1;
    csr_num   = num;
    csr_wmask = mask;
    csr_wdata = data;
    tick();
    csr_we    = 1'b0;
  endtask

  task automatic csr_chk(input string tag, input logic [13:0] num, input logic [31:0] exp);
    csr_num = num;
    #1;
    check_eq(tag, csr_rdata, exp);
  endtask

  // Present one WB event for a cycle and queue the redirect target it must produce.
  task automatic wb_event(input logic [5:0] vec, input logic ertn, input logic [31:0] pc,
                          input logic [31:0] vaddr, input logic [31:0] exp_target);
    ws_valid   = 1'b1;
    ws_exc_vec = vec;
    ws_ertn    = ertn;
    ws_pc      = pc;
    ws_vaddr   = vaddr;
    exp_q.push_back(exp_target);
    tick();
    ws_valid   = 1'b0;
    ws_exc_vec = 6'd0;
    ws_ertn    = 1'b0;
  endtask

  // Scoreboard monitor: while a redirect is pending its PC must match the queue head.
  always @(negedge clk) begin
    if (!reset && redirect_valid) begin
      if (exp_q.size() == 0) begin
        n_extra++;
      end else begin
        check_eq("redir_pc", redirect_pc, exp_q[0]);
        if (fs_redirect_ready) begin
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_pass = 0; n_extra = 0;
    reset = 1'b1; ws_valid = 1'b0; ws_exc_vec = 6'd0; ws_ertn = 1'b0;
    ws_pc = 32'd0; ws_vaddr = 32'd0; csr_we = 1'b0; csr_num = 14'd0;
    csr_wmask = 32'd0; csr_wdata = 32'd0; hw_int = 8'd0; fs_redirect_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    check_eq("rst_flush", {31'd0, flush}, 32'd0);
    check_eq("rst_rv", {31'd0, redirect_valid}, 32'd0);
    check_eq("rst_rpc", redirect_pc, 32'd0);
    check_eq("rst_has_int", {31'd0, has_int}, 32'd0);
    csr_chk("rst_crmd", 14'h000, 32'h0000_0008);
    csr_chk("rst_estat", 14'h005, 32'd0);
    csr_chk("rst_tval", 14'h042, 32'd0);
    csr_chk("rst_era", 14'h006, 32'd0);
    csr_chk("unimpl", 14'h123, 32'd0);

    // Hardware interrupt lines land in IS[9:2]
    hw_int = 8'hA5;
    tick();
    csr_chk("estat_hw", 14'h005, 32'h0000_0294);
    hw_int = 8'h00;
    tick();

    // ALE
    csr_write(14'h00C, 32'hFFFF_FFFF, 32'h1C00_8000);
    csr_write(14'h000, 32'h0000_0004, 32'h0000_0004);
    wb_event(6'b100000, 1'b0, 32'h1C00_0100, 32'h0000_1002, 32'h1C00_8000);
    check_eq("ale_flush", {31'd0, flush}, 32'd1);
    check_eq("ale_rv", {31'd0, redirect_valid}, 32'd1);
    check_eq("ale_rpc", redirect_pc, 32'h1C00_8000);
    csr_chk("ale_estat", 14'h005, 32'h0009_0000);
    csr_chk("ale_era", 14'h006, 32'h1C00_0100);
    csr_chk("ale_badv", 14'h007, 32'h0000_1002);
    csr_chk("ale_crmd", 14'h000, 32'h0000_0008);
    csr_chk("ale_prmd", 14'h001, 32'h0000_0004);
    tick();
    check_eq("ale_done", {31'd0, flush}, 32'd0);

    // ertn restore
    csr_write(14'h001, 32'hFFFF_FFFF, 32'h0000_0007);
    csr_write(14'h006, 32'hFFFF_FFFF, 32'h1C00_0200);
    wb_event(6'b000000, 1'b1, 32'h1C00_0204, 32'd0, 32'h1C00_0200);
    check_eq("ertn_rpc", redirect_pc, 32'h1C00_0200);
    csr_chk("ertn_crmd", 14'h000, 32'h0000_000F);
    tick();

    // Stall with a second exception presented during REDIR
    fs_redirect_ready = 1'b0;
    wb_event(6'b000010, 1'b0, 32'h1C00_0300, 32'd0, 32'h1C00_8000);
    for (int i = 0; i < 3; i++) begin
      check_eq("stall_flush", {31'd0, flush}, 32'd1);
      check_eq("stall_rv", {31'd0, redirect_valid}, 32'd1);
      ws_valid = 1'b1; ws_exc_vec = 6'b000100; ws_pc = 32'h1C00_0400;
      tick();
    end
    ws_valid = 1'b0; ws_exc_vec = 6'd0;
    fs_redirect_ready = 1'b1;
    check_eq("stall_flush4", {31'd0, flush}, 32'd1);
    tick();
    check_eq("stall_done", {31'd0, flush}, 32'd0);
    csr_chk("stall_era", 14'h006, 32'h1C00_0300);
    csr_chk("stall_estat", 14'h005, 32'h000C_0000);
    csr_chk("stall_badv", 14'h007, 32'h0000_1002);
    csr_chk("stall_prmd", 14'h001, 32'h0000_0007);

    // Periodic timer
    csr_write(14'h004, 32'hFFFF_FFFF, 32'h0000_0800);
    csr_write(14'h000, 32'h0000_0004, 32'h0000_0004);
    csr_write(14'h041, 32'hFFFF_FFFF, 32'h0000_0013);
    csr_chk("tval_load", 14'h042, 32'd16);
    repeat (8) tick();
    csr_chk("tval_mid", 14'h042, 32'd8);
    check_eq("tmr_no_int", {31'd0, has_int}, 32'd0);
    repeat (8) tick();
    csr_chk("tval_zero", 14'h042, 32'd0);
    csr_chk("tmr_is11", 14'h005, 32'h000C_0800);
    check_eq("tmr_has_int", {31'd0, has_int}, 32'd1);
    tick();
    csr_chk("tval_reload", 14'h042, 32'd16);
    csr_write(14'h044, 32'hFFFF_FFFF, 32'h0000_0001);
    check_eq("ticlr_has_int", {31'd0, has_int}, 32'd0);

    // One-shot timer: expiry collides with TICLR (set wins), then holds at zero
    csr_write(14'h041, 32'hFFFF_FFFF, 32'h0000_0005);
    repeat (3) tick();
    csr_chk("os_tval1", 14'h042, 32'd1);
    csr_write(14'h044, 32'hFFFF_FFFF, 32'h0000_0001);
    csr_chk("os_setwins", 14'h005, 32'h000C_0800);
    csr_write(14'h044, 32'hFFFF_FFFF, 32'h0000_0001);
    repeat (3) tick();
    csr_chk("os_hold_is", 14'h005, 32'h000C_0000);
    csr_chk("os_hold_tval", 14'h042, 32'd0);
    csr_write(14'h041, 32'hFFFF_FFFF, 32'h0000_0000);

    // Collision: exc + ertn + CSR write to ERA
    csr_we = 1'b1; csr_num = 14'h006; csr_wmask = 32'hFFFF_FFFF; csr_wdata = 32'hDEAD_BEEF;
    wb_event(6'b001000, 1'b1, 32'h1C00_0500, 32'd0, 32'h1C00_8000);
    csr_we = 1'b0;
    check_eq("coll_rpc", redirect_pc, 32'h1C00_8000);
    csr_chk("coll_era", 14'h006, 32'h1C00_0500);
    csr_chk("coll_estat", 14'h005, 32'h000D_0000);
    tick();

    // Cause priority and BADV selection
    wb_event(6'b010000, 1'b0, 32'h1C00_0600, 32'h0000_0777, 32'h1C00_8000);
    csr_chk("adef_estat", 14'h005, 32'h0008_0000);
    csr_chk("adef_badv", 14'h007, 32'h1C00_0600);
    tick();
    wb_event(6'b100001, 1'b0, 32'h1C00_0700, 32'h0000_0888, 32'h1C00_8000);
    csr_chk("int_estat", 14'h005, 32'h0000_0000);
    csr_chk("int_badv", 14'h007, 32'h1C00_0600);
    tick();

    // Reset while waiting in REDIR
    csr_write(14'h000, 32'h0000_01FF, 32'h0000_0010);
    fs_redirect_ready = 1'b0;
    wb_event(6'b000100, 1'b0, 32'h1C00_0800, 32'd0, 32'h1C00_8000);
    check_eq("pre_rst_rv", {31'd0, redirect_valid}, 32'd1);
    csr_chk("pre_rst_crmd", 14'h000, 32'h0000_0010);
    reset = 1'b1;
    tick();
    check_eq("redir_rst_flush", {31'd0, flush}, 32'd0);
    check_eq("redir_rst_rv", {31'd0, redirect_valid}, 32'd0);
    check_eq("redir_rst_rpc", redirect_pc, 32'd0);
    csr_chk("redir_rst_crmd", 14'h000, 32'h0000_0008);
    csr_chk("redir_rst_prmd", 14'h001, 32'h0000_0000);
    exp_q.delete();
    reset = 1'b0;
    fs_redirect_ready = 1'b1;
    repeat (3) tick();

    check_eq("sb_empty", exp_q.size(), 32'd0);
    check_eq("unexpected_redir", n_extra, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception and flush controller for the five-stage LoongArch pipeline. It sits beside the write-back stage and consumes that stage's per-instruction exception flags and `ertn` marker. It owns the exception CSRs and a countdown timer. When an exception or `ertn` retires, it flushes every stage and holds a PC redirect toward fetch until fetch accepts it.

## Interface
Parameters:
- `TIMER_W`, default 32: width of the timer counter (TVAL).

Ports (name, direction, width, meaning):
- `clk` in 1: single clock domain.
- `reset` in 1: synchronous, active-high reset.
- `ws_valid` in 1: WB stage holds a valid instruction.
- `ws_exc_vec` in 6: one-hot-or-more flags {ale, adef, ine, sys, brk, int}.
- `ws_ertn` in 1: WB instruction is `ertn`.
- `ws_pc` in 32: PC of the WB instruction.
- `ws_vaddr` in 32: faulting address, used for ALE only.
- `csr_we` in 1: CSR write strobe from WB.
- `csr_num` in 14: CSR address, shared by the read and write ports.
- `csr_wmask` in 32: CSR write bit mask.
- `csr_wdata` in 32: CSR write data.
- `csr_rdata` out 32: combinational read of `csr_num`. Unimplemented addresses read 0.
- `hw_int` in 8: external interrupt lines, sampled each cycle into ESTAT.IS[9:2].
- `has_int` out 1: interrupt pending, delivered to ID for tagging.
- `flush` out 1: kill all stage valids.
- `redirect_valid` out 1: redirect request toward fetch.
- `redirect_pc` out 32: target PC for the redirect.
- `fs_redirect_ready` in 1: fetch accepts the redirect.

## Operation
- CSR set: CRMD 0x0, PRMD 0x1, ECFG 0x4, ESTAT 0x5, ERA 0x6, BADV 0x7, EENTRY 0xC, TCFG 0x41, TVAL 0x42, TICLR 0x44.
- CSR write semantics: new = (old & ~wmask) | (wdata & wmask).
  - TVAL and ESTAT.IS[12:2] are read-only.
  - A TICLR write with bit0 set clears IS[11].
- Event qualification:
  - exc = `ws_valid` & |`ws_exc_vec`.
  - ertn = `ws_valid` & `ws_ertn` & ~exc.
  - `csr_we` is ignored when exc is set.
- Ecode priority: int(0x0) > adef(0x8) > ine(0xD) > sys(0xB) > brk(0xC) > ale(0x9).
- On exc:
  - PRMD.{PIE,PPLV} ← CRMD.{IE,PLV}; CRMD.{IE,PLV} ← 0.
  - ESTAT.Ecode ← code; ERA ← `ws_pc`.
  - BADV ← `ws_vaddr` for ale, `ws_pc` for adef; BADV is unchanged for other causes.
  - Captured target is EENTRY.
- On ertn: CRMD.{IE,PLV} ← PRMD.{PIE,PPLV}; captured target is ERA.
- `has_int` = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]).
- Timer:
  - A TCFG write with En=1 loads TVAL ← {InitVal, 2'b00}.
  - While En=1 and TVAL≠0, TVAL decrements by 1 per cycle.
  - When TVAL goes 1→0, IS[11] is set. If Periodic=1, TVAL reloads on the next cycle; otherwise TVAL stays at 0.
  - TVAL==0 with En=1 and Periodic=0 is a hold state, with no further sets of IS[11].

State machine:
- RUN:
  - `flush`=0, `redirect_valid`=0.
  - exc or ertn → REDIR. The CSR updates and the target latch happen on the same edge.
- REDIR:
  - `flush`=1, `redirect_valid`=1, `redirect_pc` = latched target (stable).
  - WB events and CSR writes are ignored.
  - `fs_redirect_ready`=1 → RUN.

## Timing
- Reset values:
  - State RUN; `flush`=0, `redirect_valid`=0, `redirect_pc`=0.
  - CRMD=0x8 (DA=1). PRMD, ECFG, ESTAT, ERA, BADV, EENTRY, TCFG, TVAL are all 0.
  - `has_int`=0.
- Latency:
  - An event in cycle N produces `flush`/`redirect_valid` high from cycle N+1.
  - The minimum REDIR residency is 1 cycle (when ready is high in N+1).
- Handshake: the redirect completes on the cycle with `redirect_valid` & `fs_redirect_ready`. `redirect_pc` does not change while it is waiting.
- Simultaneous events:
  - exc and `ws_ertn` together: the exception wins.
  - exc and `csr_we` together: the write is dropped.
  - A timer 1→0 transition coinciding with a TICLR clear: the set wins.
- `csr_rdata` reflects writes from the following cycle (no bypass).
- Reset asserted during REDIR: the next cycle is RUN with all outputs at reset values, and no redirect completes.

## Test plan
- ALE: `ws_valid`=1, `ws_exc_vec`=6'b100000, `ws_pc`=0x1C000100, `ws_vaddr`=0x1002, EENTRY=0x1C008000 → next cycle `flush`=1, `redirect_pc`=0x1C008000, ESTAT.Ecode=0x9, ERA=0x1C000100, BADV=0x1002, CRMD.IE=0.
- ertn restore: PRMD={PIE=1,PPLV=3}, ERA=0x1C000200, pulse `ws_ertn` → `redirect_pc`=0x1C000200, CRMD.IE=1, CRMD.PLV=3.
- Stall: hold `fs_redirect_ready`=0 for 3 cycles after an event → `flush`/`redirect_valid` stay high for 4 cycles with `redirect_pc` constant. A second exc presented during the stall leaves ERA unchanged.
- Timer: ECFG.LIE[11]=1, CRMD.IE=1, TCFG=0x13 (InitVal=4, Periodic=1, En=1) → TVAL 16→0 over 16 cycles, then IS[11]=1 and `has_int`=1, then TVAL reloads to 16. A TICLR write of 1 → `has_int`=0.
- Collisions: exc with `ws_ertn`=1 and a `csr_we` to ERA in the same cycle → target is EENTRY, ERA=`ws_pc`, and the CSR write is lost.
- Reset in REDIR: assert `reset` while `fs_redirect_ready`=0 → next cycle `flush`=0, `redirect_valid`=0, CRMD=0x8.
